ultrasonido_emulador: RTL and testbench

//  Sensor-side model of an HC-SR04 ultrasonic ranger, synthesizable for hardware-in-loop tests and benches.

---
 rtl/ultrasonido_pkg.sv | 22 ++
 rtl/ultrasonido_trig_sync.sv | 55 +++++
 rtl/ultrasonido_emulador.sv | 170 +++++++++++++++++
 tb/tb_ultrasonido_emulador.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonido_pkg.sv
// rtl/ultrasonido_pkg.sv - shared types and helpers for the HC-SR04 sensor emulator
// Purpose: FSM state encoding, speed-of-sound constant and the echo-cycles-per-cm
//          helper used to derive the default distance scaling.
// Ports:   none (package)
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_MEAS,
    DELAY,
    ECHO,
    HOLDOFF
  } state_e;

  localparam int SOUND_SPEED_CMS = 34300;

  // Round-trip echo cycles per cm: the pulse covers the distance twice.
  function automatic int cycles_per_cm(input int freq);
    return int'((longint'(freq) * 2) / SOUND_SPEED_CMS);
  endfunction

endpackage

// File: rtl/ultrasonido_trig_sync.sv
// rtl/ultrasonido_trig_sync.sv - TRIG input register, optional synchronizer and edge detect
// Purpose: registers trig_i once (optionally behind a 2-flop synchronizer when
//          ULTRASONIDO_EMU_SYNC_EN is defined) and derives rise/fall strobes from it.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   trig_i       in   raw TRIG from the controller
//   trig_s_o     out  registered TRIG
//   trig_rise_o  out  trig_s 0->1 this cycle
//   trig_fall_o  out  trig_s 1->0 this cycle
module ultrasonido_trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic trig_s_o,
  output logic trig_rise_o,
  output logic trig_fall_o
);

  logic trig_in;

`ifdef ULTRASONIDO_EMU_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], trig_i};
    end
  end

  assign trig_in = sync_q[1];
`else
  assign trig_in = trig_i;
`endif

  logic trig_s_q;
  logic trig_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s_q    <= trig_in;
      trig_prev_q <= trig_s_q;
    end
  end

  assign trig_s_o    = trig_s_q;
  assign trig_rise_o = trig_s_q & ~trig_prev_q;
  assign trig_fall_o = ~trig_s_q & trig_prev_q;

endmodule

// File: rtl/ultrasonido_emulador.sv
// rtl/ultrasonido_emulador.sv - HC-SR04 ultrasonic ranger sensor-side emulator
// Purpose: answers a TRIG pulse of at least MIN_TRIG_CYCLES with an ECHO pulse whose width
//          encodes the commanded distance (or a no-object timeout), after a fixed burst delay,
//          followed by a holdoff during which TRIG is ignored.
//          Build macro ULTRASONIDO_EMU_SYNC_EN adds a 2-flop TRIG synchronizer (+2 cycles).
// Ports:
//   clk               in   system clock
//   rst               in   synchronous, active-high reset
//   trig_i            in   TRIG from controller
//   distance_cm_i     in   commanded distance, cm (9 bits)
//   object_present_i  in   0 = no target, timeout-width echo
//   echo_o            out  ECHO to controller, registered
//   busy_o            out  high in DELAY, ECHO and HOLDOFF
//   meas_done_o       out  1-cycle pulse when ECHO falls
//   trig_err_o        out  1-cycle pulse on a too-short TRIG
module ultrasonido_emulador
  import ultrasonido_pkg::*;
#(
  parameter int CLOCK_FREQ        = 50_000_000,
  parameter int MIN_TRIG_CYCLES   = 500,
  parameter int ECHO_DELAY_CYCLES = 23_000,
  parameter int CYCLES_PER_CM     = cycles_per_cm(CLOCK_FREQ),
  parameter int MIN_DIST_CM       = 2,
  parameter int MAX_DIST_CM       = 400,
  parameter int TIMEOUT_CYCLES    = 1_900_000,
  parameter int HOLDOFF_CYCLES    = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_i,
  input  logic [8:0] distance_cm_i,
  input  logic       object_present_i,
  output logic       echo_o,
  output logic       busy_o,
  output logic       meas_done_o,
  output logic       trig_err_o
);

  localparam int ECHO_MAX = (TIMEOUT_CYCLES > MAX_DIST_CM * CYCLES_PER_CM) ?
                            TIMEOUT_CYCLES : MAX_DIST_CM * CYCLES_PER_CM;
  // One counter is shared by delay, echo and holdoff, so it must hold the longest of them.
  localparam int CNT_MAX0 = (ECHO_MAX > ECHO_DELAY_CYCLES) ? ECHO_MAX : ECHO_DELAY_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > HOLDOFF_CYCLES) ? CNT_MAX0 : HOLDOFF_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int TCNT_W   = $clog2(MIN_TRIG_CYCLES + 1);

  logic trig_s;
  logic trig_rise;
  logic trig_fall;

  ultrasonido_trig_sync u_trig_sync (
    .clk         (clk),
    .rst         (rst),
    .trig_i      (trig_i),
    .trig_s_o    (trig_s),
    .trig_rise_o (trig_rise),
    .trig_fall_o (trig_fall)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                echo_q, echo_d;
  logic                meas_done_q, meas_done_d;
  logic                trig_err_q, trig_err_d;

  // Echo length from the live inputs; only captured on the TRIG fall, so later
  // input changes have no effect on the pulse in flight.
  logic [8:0]          dist_eff;
  logic [CNT_W-1:0]    len_calc;

  always_comb begin
    dist_eff = (int'(distance_cm_i) < MIN_DIST_CM) ? 9'(MIN_DIST_CM) : distance_cm_i;
    if (!object_present_i || int'(distance_cm_i) > MAX_DIST_CM) begin
      len_calc = CNT_W'(TIMEOUT_CYCLES);
    end else begin
      len_calc = CNT_W'(dist_eff) * CNT_W'(CYCLES_PER_CM);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    len_d       = len_q;
    echo_d      = echo_q;
    meas_done_d = 1'b0;
    trig_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          tcnt_d  = TCNT_W'(1);
          state_d = TRIG_MEAS;
        end
      end
      TRIG_MEAS: begin
        if (trig_fall) begin
          if (tcnt_q >= TCNT_W'(MIN_TRIG_CYCLES)) begin
            len_d   = len_calc;
            cnt_d   = '0;
            state_d = DELAY;
          end else begin
            trig_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else if (trig_s && tcnt_q < TCNT_W'(MIN_TRIG_CYCLES)) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      DELAY: begin
        // Terminal count is N-1 so the registered echo rises exactly N edges after entry.
        if (cnt_q == CNT_W'(ECHO_DELAY_CYCLES - 1)) begin
          cnt_d   = '0;
          echo_d  = 1'b1;
          state_d = ECHO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ECHO: begin
        if (cnt_q == len_q - CNT_W'(1)) begin
          cnt_d       = '0;
          echo_d      = 1'b0;
          meas_done_d = 1'b1;
          state_d     = HOLDOFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      len_q       <= '0;
      echo_q      <= 1'b0;
      meas_done_q <= 1'b0;
      trig_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      len_q       <= len_d;
      echo_q      <= echo_d;
      meas_done_q <= meas_done_d;
      trig_err_q  <= trig_err_d;
    end
  end

  assign echo_o      = echo_q;
  assign busy_o      = (state_q == DELAY) || (state_q == ECHO) || (state_q == HOLDOFF);
  assign meas_done_o = meas_done_q;
  assign trig_err_o  = trig_err_q;

endmodule

// File: tb/tb_ultrasonido_emulador.sv
// tb/tb_ultrasonido_emulador.sv - scoreboard bench for the HC-SR04 sensor emulator
module tb_ultrasonido_emulador;

  localparam int MIN_TRIG = 500;
  localparam int DLY      = 40;
  localparam int CPC      = 5;
  localparam int MIN_D    = 2;
  localparam int MAX_D    = 400;
  localparam int TMO      = 2500;
  localparam int HOLD     = 300;
`ifdef ULTRASONIDO_EMU_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    int rise;
    int width;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [8:0] distance;
  logic       present;
  logic       echo_o;
  logic       busy_o;
  logic       meas_done_o;
  logic       trig_err_o;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   err_q[$];
  bit   in_echo = 0;
  bit   have_cur = 0;
  int   width = 0;
  exp_t cur;

  ultrasonido_emulador #(
    .MIN_TRIG_CYCLES   (MIN_TRIG),
    .ECHO_DELAY_CYCLES (DLY),
    .CYCLES_PER_CM     (CPC),
    .MIN_DIST_CM       (MIN_D),
    .MAX_DIST_CM       (MAX_D),
    .TIMEOUT_CYCLES    (TMO),
    .HOLDOFF_CYCLES    (HOLD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .trig_i           (trig),
    .distance_cm_i    (distance),
    .object_present_i (present),
    .echo_o           (echo_o),
    .busy_o           (busy_o),
    .meas_done_o      (meas_done_o),
    .trig_err_o       (trig_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int exp_len(input int d, input bit p);
    if (!p || d > MAX_D) return TMO;
    if (d < MIN_D) return MIN_D * CPC;
    return d * CPC;
  endfunction

  // Monitor: pops the expected echo on each rise, checks width and the done strobe on the fall.
  always @(negedge clk) begin
    if (rst) begin
      in_echo  = 0;
      have_cur = 0;
      exp_q.delete();
      err_q.delete();
    end else begin
      if (echo_o && !in_echo) begin
        in_echo = 1;
        width   = 1;
        chk("busy_in_echo", busy_o, 1);
        if (exp_q.size() == 0) begin
          chk("echo_unexpected", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1;
          chk("echo_rise_cyc", cyc, cur.rise);
        end
      end else if (echo_o) begin
        width++;
      end else if (in_echo) begin
        in_echo = 0;
        chk("meas_done_at_fall", meas_done_o, 1);
        if (have_cur) chk("echo_width", width, cur.width);
        have_cur = 0;
      end else if (meas_done_o) begin
        chk("meas_done_stray", 1, 0);
      end
      if (trig_err_o) begin
        if (err_q.size() == 0) chk("trig_err_unexpected", 1, 0);
        else chk("trig_err_cyc", cyc, err_q.pop_front());
      end
    end
  end

  task automatic send_trig(input int n, input int d, input bit p, input bit expect_it);
    exp_t e;
    @(negedge clk);
    distance = 9'(d);
    present  = p;
    trig     = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
    if (expect_it) begin
      if (n >= MIN_TRIG) begin
        e.rise  = cyc + 2 + DLY + SYNC_LAT;
        e.width = exp_len(d, p);
        exp_q.push_back(e);
      end else begin
        err_q.push_back(cyc + 2 + SYNC_LAT);
      end
    end
    repeat (SYNC_LAT + 3) @(negedge clk);
    distance = 9'($urandom_range(0, 511));
    present  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || busy_o || echo_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_echo(input logic level, input int budget);
    int n = 0;
    while (echo_o !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_echo_timeout", 1, 0);
  endtask

  initial begin
    rst      = 1'b1;
    trig     = 1'b0;
    distance = '0;
    present  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_echo", echo_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_meas_done", meas_done_o, 0);
    chk("rst_trig_err", trig_err_o, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_trig(500, 10, 1, 1);
    wait_idle(10000);

    send_trig(499, 10, 1, 1);
    chk("busy_after_short_trig", busy_o, 0);
    wait_idle(10000);
    chk("no_echo_after_short_trig", echo_o, 0);

    send_trig(500, 10, 0, 1);
    wait_idle(10000);
    send_trig(500, 450, 1, 1);
    wait_idle(10000);
    send_trig(500, 0, 1, 1);
    wait_idle(10000);
    send_trig(500, 1, 1, 1);
    wait_idle(10000);
    send_trig(500, 2, 1, 1);
    wait_idle(10000);
    send_trig(500, 400, 1, 1);
    wait_idle(10000);
    send_trig(800, 37, 1, 1);
    wait_idle(10000);

    send_trig(500, 200, 1, 1);
    wait_echo(1'b1, 2000);
    send_trig(20, 5, 1, 0);
    wait_echo(1'b0, 2000);
    send_trig(20, 5, 1, 0);
    repeat (2) @(negedge clk);
    send_trig(500, 5, 1, 0);
    wait_idle(10000);
    send_trig(500, 123, 1, 1);
    wait_idle(10000);

    send_trig(500, 300, 1, 1);
    wait_echo(1'b1, 2000);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_echo_echo", echo_o, 0);
    chk("rst_mid_echo_busy", busy_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_trig(500, 50, 1, 1);
    wait_idle(10000);

    for (int i = 0; i < 4; i++) begin
      send_trig(MIN_TRIG + int'($urandom_range(0, 20)), int'($urandom_range(0, 511)),
                1'($urandom_range(0, 1)), 1);
      wait_idle(10000);
    end

    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
